hid_gamepad_events: RTL and testbench
=====================================

Name: hid_gamepad_events

Overview:
- Sits directly downstream of the USB HID host, in the clk_usb domain.
- Consumes raw HID reports (report word + one-cycle valid) and converts them into a 16-bit logical button/direction state.
- From that state it generates a serialized stream of press, release and auto-repeat events.
- Events are buffered in a small FIFO with a valid/ready handshake. Menu/cursor logic and a later CDC stage toward the pixel domain consume them.

Parameters:
- C_report_bytes, 8, report width in bytes; byte k = i_report[8k+7:8k].
- C_axis_x_byte, 3, byte index of the X axis.
- C_axis_y_byte, 4, byte index of the Y axis.
- C_btn_byte0, 5, byte index whose bits [7:4] give buttons 0-3.
- C_btn_byte1, 6, byte index whose bits [7:0] give buttons 4-11.
- C_axis_lo, 8'h40, axis value strictly below this means left/up.
- C_axis_hi, 8'hC0, axis value strictly above this means right/down.
- C_tick_div, 6000, clk_i cycles per tick (1 ms at 6 MHz); must be >= 2.
- C_repeat_delay, 400, ticks a direction is held before the first repeat.
- C_repeat_period, 100, ticks between subsequent repeats.
- C_fifo_depth, 8, event FIFO depth; must be a power of 2.

Ports:
- clk_i  in  1  USB-domain clock.
- rstn_i  in  1  asynchronous, active-low reset.
- i_report  in  C_report_bytes*8  HID report from the host.
- i_report_valid  in  1  one-cycle strobe; i_report is valid this cycle.
- o_evt_data  out  6  [5:4] type (01 press, 10 release, 11 repeat), [3:0] bit index.
- o_evt_valid  out  1  FIFO head valid.
- i_evt_ready  in  1  consumer accepts the head when valid && ready.
- o_state  out  16  current emitted logical state.
- o_fifo_level  out  $clog2(C_fifo_depth)+1  FIFO occupancy.
- o_overflow  out  1  sticky: a repeat event was dropped.

Behaviour:
- Reset (async assert, sync release): o_evt_data=0, o_evt_valid=0, o_state=0, o_fifo_level=0, o_overflow=0; target=0, tick counter=0, repeat timer idle.
- Decode happens when i_report_valid=1. The target register (16 bits) loads:
  - bit0 left = X<C_axis_lo
  - bit1 right = X>C_axis_hi
  - bit2 up = Y<C_axis_lo
  - bit3 down = Y>C_axis_hi
  - bits[7:4] = byte0[7:4]
  - bits[15:8] = byte1[7:0]
- Reports with i_report_valid=0 are ignored. An identical report produces no events.
- Scanner: diff = target ^ cur (cur drives o_state). In each cycle where diff!=0 and the FIFO is not full:
  - pick the lowest set index i;
  - write {cur[i]?release:press, i};
  - toggle cur[i].
- One event per cycle. Multiple changes are emitted in ascending index order.
- FIFO full: the scanner stalls with cur unchanged. Press/release events are never lost.
- A new report mid-scan simply overwrites target; the scan continues against the new diff. A bit that changes and changes back before its turn produces no event.
- Latency, empty FIFO: i_report_valid in cycle N → target updated at end of N → FIFO write in N+1 → o_evt_valid=1 in N+2.
- Tick: a free-running counter 0..C_tick_div-1 pulses tick when it wraps.
- Auto-repeat: applies to direction bits [3:0] only. The repeat source is the lowest set bit of cur[3:0].
  - When the source changes (including to none), the timer reloads C_repeat_delay.
  - On each tick with a source present it decrements. On reaching 0 it requests a repeat event {11, source} and reloads C_repeat_period.
- A repeat is written only in a cycle where the scanner is not writing (diff==0). Otherwise it waits until diff==0; at most one repeat is pending.
- If the FIFO is full when a repeat would be written, the repeat is dropped and o_overflow is set (sticky until reset).
- FIFO: synchronous, first-word registered.
  - A simultaneous read and write when full is allowed: the read frees a slot, so the write is accepted.
  - A read when empty is ignored.
  - o_evt_data holds its last value when o_evt_valid=0.
- rstn_i asserted mid-scan or mid-repeat clears everything immediately. No event is emitted for buttons held across reset until the next report.

Decomposition:
- Shared package hid_evt_pkg holds:
  - event type constants EVT_PRESS=2'b01, EVT_RELEASE=2'b10, EVT_REPEAT=2'b11;
  - the direction bit indices 0..3;
  - the default thresholds.
- One sub-module, hid_evt_fifo: a parameterised sync FIFO (width 6, depth C_fifo_depth) with level output.
- Decode, scanner, tick and repeat logic stay in the top.

Test Plan:
- Reset, then one report X=80 Y=80 byte5=10 byte6=01 → exactly two events: 01_0100 (press 4) then 01_1000 (press 8); o_state=0x0110; o_evt_valid first high 2 cycles after the strobe.
- Then a report with all neutral values (X=Y=80, buttons 0) → events 10_0100 and 10_1000, in that order; o_state=0x0000.
- Use C_tick_div=4, C_repeat_delay=3, C_repeat_period=2, with X=00 held:
  - press 0 first;
  - first repeat 11_0000 at 12 cycles ±1 after the press is written, then every 8 cycles;
  - releasing X (X=80) stops repeats and yields 10_0000.
- Hold i_evt_ready=0 with a report setting all 16 bits (X=00 Y=00 byte5=F0 byte6=FF; only bits 0 and 2 set from the axes) → FIFO fills to 8, scanner stalls; then ready=1 → all 14 presses emerge in ascending index order; o_overflow=0.
- FIFO full and a direction held past the repeat delay, ready=0 → o_overflow=1, o_fifo_level stays 8, no press/release lost.
- Assert rstn_i low mid-scan (3 events pending) → all outputs 0 in the same cycle, nothing emitted after release until a new report.

Source files
------------

// File: rtl/hid_evt_pkg.sv
// Shared definitions for the gamepad event path: event type codes, direction
// bit positions inside the logical state word, default axis thresholds and
// small priority helpers used by the scanner and the auto-repeat logic.
package hid_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  localparam logic [7:0] AXIS_LO_DEFAULT = 8'h40;
  localparam logic [7:0] AXIS_HI_DEFAULT = 8'hC0;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_set16(input logic [15:0] v);
    lowest_set16 = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set16 = 4'(i);
    end
  endfunction

  function automatic logic [1:0] lowest_set4(input logic [3:0] v);
    lowest_set4 = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_set4 = 2'(i);
    end
  endfunction

endpackage

// File: rtl/hid_evt_fifo.sv
// Synchronous event FIFO with a registered head word.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_data   write request and data; accepted when room=1
//   room              a push this cycle will be accepted (a pop frees a slot)
//   pop               consumer ready; takes head when head_valid=1
//   head, head_valid  registered head word (holds last value while empty)
//   level             current occupancy
module hid_evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       room,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]      count, count_nxt;
  logic             pop_fire, push_fire;

  assign head_valid = (count != '0);
  assign pop_fire   = pop && head_valid;
  assign room       = (count != (AW+1)'(DEPTH)) || pop_fire;
  assign push_fire  = push && room;
  assign rd_ptr_nxt = pop_fire ? rd_ptr + 1'b1 : rd_ptr;
  assign count_nxt  = count + (AW+1)'(push_fire) - (AW+1)'(pop_fire);
  assign level      = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      // The word being written becomes the head when it lands on the next
      // read slot (empty FIFO, or a single entry popped this cycle).
      if (push_fire && (rd_ptr_nxt == wr_ptr)) head <= push_data;
      else if (count_nxt != '0)                head <= mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hid_gamepad_events.sv
// Converts HID reports into a 16-bit logical button/direction state and a
// stream of press / release / auto-repeat events, buffered in a small FIFO.
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   i_report, i_report_valid      raw report word and its one-cycle strobe
//   o_evt_data, o_evt_valid       FIFO head {type[1:0], index[3:0]} and valid
//   i_evt_ready                   consumer takes the head when valid && ready
//   o_state                       logical state already reported as events
//   o_fifo_level                  FIFO occupancy
//   o_overflow                    sticky: a repeat event had to be dropped
module hid_gamepad_events
  import hid_evt_pkg::*;
#(
  parameter int         C_report_bytes  = 8,
  parameter int         C_axis_x_byte   = 3,
  parameter int         C_axis_y_byte   = 4,
  parameter int         C_btn_byte0     = 5,
  parameter int         C_btn_byte1     = 6,
  parameter logic [7:0] C_axis_lo       = AXIS_LO_DEFAULT,
  parameter logic [7:0] C_axis_hi       = AXIS_HI_DEFAULT,
  parameter int         C_tick_div      = 6000,
  parameter int         C_repeat_delay  = 400,
  parameter int         C_repeat_period = 100,
  parameter int         C_fifo_depth    = 8
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [C_report_bytes*8-1:0]     i_report,
  input  logic                            i_report_valid,
  output logic [5:0]                      o_evt_data,
  output logic                            o_evt_valid,
  input  logic                            i_evt_ready,
  output logic [15:0]                     o_state,
  output logic [$clog2(C_fifo_depth):0]   o_fifo_level,
  output logic                            o_overflow
);

  localparam int TW        = $clog2(C_tick_div);
  localparam int C_rep_max = (C_repeat_delay > C_repeat_period) ? C_repeat_delay : C_repeat_period;
  localparam int RW        = $clog2(C_rep_max + 1);

  // Reset asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [7:0]  ax_x, ax_y, btn1;
  logic [3:0]  btn0_hi;
  logic [15:0] decoded;
  logic        unused_report;

  assign ax_x          = i_report[C_axis_x_byte*8 +: 8];
  assign ax_y          = i_report[C_axis_y_byte*8 +: 8];
  assign btn0_hi       = i_report[C_btn_byte0*8+4 +: 4];
  assign btn1          = i_report[C_btn_byte1*8 +: 8];
  assign unused_report = ^i_report;

  always_comb begin
    decoded            = '0;
    decoded[DIR_LEFT]  = (ax_x < C_axis_lo);
    decoded[DIR_RIGHT] = (ax_x > C_axis_hi);
    decoded[DIR_UP]    = (ax_y < C_axis_lo);
    decoded[DIR_DOWN]  = (ax_y > C_axis_hi);
    decoded[7:4]       = btn0_hi;
    decoded[15:8]      = btn1;
  end

  logic [15:0]   target, cur, diff;
  logic [3:0]    scan_idx;
  logic          scan_wr, fifo_room, push;
  logic [5:0]    push_data;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    src, src_q;
  logic          src_any, src_any_q, src_change;
  logic [RW-1:0] rep_timer;
  logic          rep_pend, rep_req, rep_want, rep_slot, rep_wr, rep_drop;

  assign diff     = target ^ cur;
  assign scan_idx = lowest_set16(diff);
  assign scan_wr  = (diff != '0) && fifo_room;

  assign tick = (tick_cnt == TW'(C_tick_div - 1));

  assign src        = lowest_set4(cur[3:0]);
  assign src_any    = |cur[3:0];
  assign src_change = ({src_any, src} != {src_any_q, src_q});

  // A pending repeat belongs to the current source; a source change voids it.
  assign rep_req  = !src_change && src_any && tick && (rep_timer == RW'(1));
  assign rep_want = (rep_pend || rep_req) && !src_change;
  assign rep_slot = rep_want && (diff == '0);
  assign rep_wr   = rep_slot && fifo_room;
  assign rep_drop = rep_slot && !fifo_room;

  assign push      = scan_wr || rep_wr;
  assign push_data = (diff != '0) ? {(cur[scan_idx] ? EVT_RELEASE : EVT_PRESS), scan_idx}
                                  : {EVT_REPEAT, 2'b00, src};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      target     <= '0;
      cur        <= '0;
      tick_cnt   <= '0;
      src_q      <= '0;
      src_any_q  <= 1'b0;
      rep_timer  <= RW'(C_repeat_delay);
      rep_pend   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (i_report_valid) target <= decoded;
      if (scan_wr) cur[scan_idx] <= ~cur[scan_idx];
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      src_q     <= src;
      src_any_q <= src_any;
      if (src_change) begin
        rep_timer <= RW'(C_repeat_delay);
        rep_pend  <= 1'b0;
      end else begin
        if (src_any && tick) begin
          rep_timer <= (rep_timer == RW'(1)) ? RW'(C_repeat_period) : rep_timer - 1'b1;
        end
        // Only one repeat can wait behind the scanner.
        rep_pend <= rep_want && (diff != '0);
      end
      if (rep_drop) o_overflow <= 1'b1;
    end
  end

  assign o_state = cur;

  hid_evt_fifo #(
    .WIDTH (6),
    .DEPTH (C_fifo_depth)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .room       (fifo_room),
    .pop        (i_evt_ready),
    .head       (o_evt_data),
    .head_valid (o_evt_valid),
    .level      (o_fifo_level)
  );

endmodule

// File: tb/tb_hid_gamepad_events.sv
module tb_hid_gamepad_events;

  logic        clk, rstn, rpt_valid, ready;
  logic [63:0] rpt;
  logic [5:0]  evt_data;
  logic        evt_valid;
  logic [15:0] state;
  logic [3:0]  fifo_level;
  logic        overflow;

  int          n_chk, n_fail, cyc, last_pr_cyc;
  logic [5:0]  exp_q[$];
  int          rep_cyc[$];
  logic [3:0]  rep_ok;
  logic [15:0] m_target;

  hid_gamepad_events #(
    .C_tick_div      (4),
    .C_repeat_delay  (3),
    .C_repeat_period (2)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .i_report       (rpt),
    .i_report_valid (rpt_valid),
    .o_evt_data     (evt_data),
    .o_evt_valid    (evt_valid),
    .i_evt_ready    (ready),
    .o_state        (state),
    .o_fifo_level   (fifo_level),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Logical state implied by a report, straight from the decode rules.
  function automatic logic [15:0] model_decode(input logic [7:0] x, y, b0, b1);
    return {b1, b0[7:4], (y > 8'hC0), (y < 8'h40), (x > 8'hC0), (x < 8'h40)};
  endfunction

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_report(input logic [7:0] x, y, b0, b1);
    logic [15:0] n;
    n = model_decode(x, y, b0, b1);
    for (int i = 0; i < 16; i++)
      if (n[i] != m_target[i]) exp_q.push_back({(n[i] ? 2'b01 : 2'b10), 4'(i)});
    m_target = n;
    rpt = {8'($urandom), b1, b0, y, x, 24'($urandom)};
    rpt_valid = 1'b1;
    @(posedge clk);
    #1;
    rpt_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !evt_valid) begin
        done = 1'b1;
        break;
      end
      cyc_wait(1);
    end
    chk({name, "_drained"}, {31'b0, done}, 1);
  endtask

  // Event checker: press/release in model order, repeats only for allowed sources.
  always @(negedge clk) begin
    if (rstn) begin
      chk("valid_vs_level", {31'b0, evt_valid}, {31'b0, (fifo_level != 0)});
      chk("level_max", {31'b0, (fifo_level <= 8)}, 1);
      if (evt_valid && ready) begin
        if (evt_data[5:4] == 2'b11) begin
          chk("repeat_idx", {29'b0, rep_ok[evt_data[1:0]], evt_data[3:2]}, 3'b100);
          rep_cyc.push_back(cyc);
        end else if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL evt_unexpected: got 0x%0h, expected no event", evt_data);
        end else begin
          chk("evt_data", {26'b0, evt_data}, {26'b0, exp_q.pop_front()});
          last_pr_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g1, g2, g3, nrep;
    clk = 0; rstn = 1; rpt = '0; rpt_valid = 0; ready = 1; rep_ok = 0;
    n_chk = 0; n_fail = 0; cyc = 0; last_pr_cyc = 0; m_target = '0;
    #2 rstn = 0;
    cyc_wait(3);
    chk("rst_data", {26'b0, evt_data}, 0);
    chk("rst_valid", {31'b0, evt_valid}, 0);
    chk("rst_state", {16'b0, state}, 0);
    chk("rst_level", {28'b0, fifo_level}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    rstn = 1;
    cyc_wait(4);

    // press 4 and 8, with latency
    apply_report(8'h80, 8'h80, 8'h10, 8'h01);
    chk("model_evt0", {26'b0, exp_q[0]}, 6'b01_0100);
    chk("model_evt1", {26'b0, exp_q[1]}, 6'b01_1000);
    chk("lat_n1", {31'b0, evt_valid}, 0);
    cyc_wait(1);
    chk("lat_n2", {31'b0, evt_valid}, 1);
    chk("lat_head", {26'b0, evt_data}, 6'b01_0100);
    wait_drain("press48", 20);
    chk("state_0110", {16'b0, state}, 16'h0110);

    apply_report(8'h80, 8'h80, 8'h00, 8'h00);
    wait_drain("rel48", 20);
    chk("state_0000", {16'b0, state}, 0);
    chk("hold_data", {26'b0, evt_data}, 6'b10_1000);

    // strobe low: ignored; identical report: silent
    rpt[8*3 +: 8] = 8'h00;
    rpt[8*6 +: 8] = 8'hFF;
    cyc_wait(10);
    chk("ignored_state", {16'b0, state}, 0);
    chk("ignored_level", {28'b0, fifo_level}, 0);
    apply_report(8'h80, 8'h80, 8'h00, 8'h00);
    cyc_wait(10);
    chk("same_level", {28'b0, fifo_level}, 0);

    // auto-repeat timing, left held
    rep_ok = 4'b0001;
    rep_cyc.delete();
    apply_report(8'h00, 8'h80, 8'h00, 8'h00);
    wait_drain("press0", 20);
    chk("state_0001", {16'b0, state}, 16'h0001);
    cyc_wait(40);
    chk("rep_count", {31'b0, (rep_cyc.size() >= 3)}, 1);
    g1 = (rep_cyc.size() > 0) ? rep_cyc[0] - last_pr_cyc : -1;
    g2 = (rep_cyc.size() > 1) ? rep_cyc[1] - rep_cyc[0] : -1;
    g3 = (rep_cyc.size() > 2) ? rep_cyc[2] - rep_cyc[1] : -1;
    chk_rng("rep_first_gap", g1, 9, 14);
    chk("rep_gap2", g2, 8);
    chk("rep_gap3", g3, 8);
    apply_report(8'h80, 8'h80, 8'h00, 8'h00);
    wait_drain("rel0", 30);
    rep_ok = 4'b0000;
    nrep = rep_cyc.size();
    cyc_wait(30);
    chk("rep_stopped", rep_cyc.size(), nrep);

    // fill with ready low: 14 presses, scanner stalls
    ready = 0;
    rep_ok = 4'b0001;
    apply_report(8'h00, 8'h00, 8'hF0, 8'hFF);
    chk("fill_model", exp_q.size(), 14);
    cyc_wait(20);
    chk("fill_level", {28'b0, fifo_level}, 8);
    chk("fill_state", {16'b0, state}, 16'h03F5);
    chk("fill_ovf", {31'b0, overflow}, 0);
    ready = 1;
    wait_drain("fill", 80);
    chk("fill_state_all", {16'b0, state}, 16'hFFF5);
    chk("fill_ovf_after", {31'b0, overflow}, 0);
    rep_ok = 4'b0101;
    apply_report(8'h80, 8'h80, 8'h00, 8'h00);
    wait_drain("fill_rel", 60);
    rep_ok = 4'b0000;
    chk("fill_rel_state", {16'b0, state}, 0);

    // full FIFO while left is held past the delay: repeat dropped
    ready = 0;
    rep_ok = 4'b0001;
    apply_report(8'h00, 8'h80, 8'hF0, 8'h07);
    chk("ovf_model", exp_q.size(), 8);
    cyc_wait(40);
    chk("ovf_set", {31'b0, overflow}, 1);
    chk("ovf_level", {28'b0, fifo_level}, 8);
    chk("ovf_state", {16'b0, state}, 16'h07F1);
    ready = 1;
    wait_drain("ovf", 60);
    chk("ovf_sticky", {31'b0, overflow}, 1);
    apply_report(8'h80, 8'h80, 8'h00, 8'h00);
    wait_drain("ovf_rel", 60);
    rep_ok = 4'b0000;
    chk("ovf_rel_state", {16'b0, state}, 0);
    chk("ovf_sticky2", {31'b0, overflow}, 1);

    // reset mid-scan
    ready = 0;
    apply_report(8'h80, 8'h80, 8'h00, 8'h07);
    @(posedge clk);
    #3 rstn = 0;
    #1;
    chk("mid_rst_data", {26'b0, evt_data}, 0);
    chk("mid_rst_valid", {31'b0, evt_valid}, 0);
    chk("mid_rst_state", {16'b0, state}, 0);
    chk("mid_rst_level", {28'b0, fifo_level}, 0);
    chk("mid_rst_ovf", {31'b0, overflow}, 0);
    exp_q.delete();
    m_target = '0;
    cyc_wait(2);
    rstn = 1;
    ready = 1;
    cyc_wait(30);
    chk("post_rst_state", {16'b0, state}, 0);
    chk("post_rst_valid", {31'b0, evt_valid}, 0);
    apply_report(8'h80, 8'h80, 8'h00, 8'h01);
    wait_drain("post_rst_press", 20);
    chk("post_rst_state2", {16'b0, state}, 16'h0100);
    apply_report(8'h80, 8'h80, 8'h00, 8'h00);
    wait_drain("post_rst_rel", 20);
    chk("final_state", {16'b0, state}, 0);

    cyc_wait(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
